spi_master_mode: RTL and testbench
==================================

// Module: spi_master_mode
// PURPOSE
//   Parametrised full-duplex SPI master, next generation of the single-mode BITS-wide master.
//   - Adds: all four CPOL/CPHA modes, programmable SCLK divider, N_SS slave selects,
//     captured MISO word and a busy flag.
//   - Sits between a local register/command interface and off-chip SPI slaves.
// PARAMETERS
//   BITS     8  word length per transfer (>=2)
//   N_SS     1  number of active-low slave-select lines (>=1)
//   CLK_DIV  2  clk cycles per SCLK half-period (>=1)
//   SS_W     derived localparam = (N_SS>1) ? $clog2(N_SS) : 1
// PORTS
//   clk         in   1       system clock, all logic on rising edge
//   rst_n       in   1       asynchronous active-low reset
//   data_ready  in   1       transfer request strobe, sampled only in IDLE
//   data        in   BITS    TX word, latched with request
//   cs_sel      in   SS_W    slave index, latched with request
//   cpol        in   1       SCLK idle level, latched with request
//   cpha        in   1       0: sample leading edge, 1: sample trailing edge; latched
//   lsb_first   in   1       present only with SPI_LSB_FIRST_EN; latched with request
//   miso        in   1       serial data from slave
//   sclk        out  1       serial clock
//   mosi        out  1       serial data to slave
//   ss_n        out  N_SS    slave selects, one-hot low during transfer
//   busy        out  1       high from accept until data_sent inclusive
//   data_sent   out  1       1-cycle pulse at end of transfer
//   rx_data     out  BITS    word captured from miso, valid when data_sent=1, held until next end
// BEHAVIOUR
//   Reset (async): IDLE; sclk=0, mosi=0, ss_n=all 1, busy=0, data_sent=0, rx_data=0.
//   While rst_n=0 and after release: sclk=0 until the first accepted request latches cpol.
//   FSM: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
//   - IDLE: sclk=latched cpol. data_ready=1 and cs_sel<N_SS at edge T -> latch data/cs_sel/cpol/cpha.
//     From T+1: busy=1, ss_n[cs_sel]=0, sclk=cpol.
//     data_ready with cs_sel>=N_SS: ignored, no busy, no data_sent.
//   - SETUP: CLK_DIV cycles. If cpha=0, mosi = first bit from T+1.
//   - XFER: 2*BITS half-periods of CLK_DIV cycles; sclk toggles at the start of each.
//     - cpha=0: sample miso on odd toggles (leading), shift mosi on even toggles (trailing),
//       except after the last.
//     - cpha=1: mosi drives next bit on leading toggles, sample on trailing.
//   - HOLD: CLK_DIV cycles, sclk=cpol, ss_n still low.
//   - End: on the cycle after HOLD, ss_n=all 1, rx_data updated, data_sent=1, busy=1.
//     Next cycle: busy=0, IDLE. A request is acceptable in that same cycle.
//   - Latency: data_sent at T+1+(2*BITS+2)*CLK_DIV.
//   Divider: internal counter 0..CLK_DIV-1, reset to 0 on every state entry.
//   data_ready / input changes while busy: ignored, transfer unaffected.
//   Bit order: MSB first; mosi=0 outside SETUP/XFER/HOLD.
//   Reset mid-transfer: immediate abort to reset values, no data_sent, rx_data=0.
// CONFIGURATION
//   SPI_LSB_FIRST_EN defined: lsb_first port exists; latched 1 -> TX and RX both LSB first.
//   SPI_LSB_FIRST_EN undefined: no lsb_first port; always MSB first.
// TESTING
//   1. BITS=8, CLK_DIV=2, mode 0, data=8'h35, miso looped to mosi, request at T.
//      -> 8 leading edges; mosi 0,0,1,1,0,1,0,1; data_sent at T+37; rx_data=8'h35.
//   2. Mode 3 (cpol=1, cpha=1), data=8'hA5, miso tied 1.
//      -> sclk idles 1, mosi changes on falling edges; rx_data=8'hFF.
//   3. N_SS=4, cs_sel=2.
//      -> ss_n=4'b1011 during transfer, 4'b1111 after.
//      cs_sel=5 with N_SS=4 (SS_W=2: use cs_sel=3 on N_SS=3) -> no busy, ss_n unchanged.
//   4. data_ready re-pulsed with data=8'h00 mid-transfer of 8'hC3.
//      -> mosi still shifts 8'hC3; exactly one data_sent.
//   5. rst_n low at half-period 5 of XFER.
//      -> ss_n=all 1, sclk=0, busy=0 immediately; no data_sent.
//      New request afterwards completes normally.
//   6. With SPI_LSB_FIRST_EN, lsb_first=1, data=8'h01, loopback.
//      -> first mosi bit 1; rx_data=8'h01.

Source files
------------

// File: rtl/spi_master_mode_if.sv
// -----------------------------------------------------------------------------
// spi_master_mode_if
//   Bundles the command side (request strobe, TX word, slave index, mode bits,
//   completion status) and the SPI pin side (sclk/mosi/miso/ss_n) of
//   spi_master_mode.
//
//   Optional feature macro: SPI_LSB_FIRST_EN adds the lsb_first signal.
//
//   Modports
//     slave  : used by spi_master_mode (receives commands, drives the SPI pins)
//     master : used by whatever issues commands and models the SPI slave
//
//   Signals
//     data_ready  request strobe            data       TX word (BITS)
//     cs_sel      slave index (SS_W)        cpol/cpha  SPI mode
//     lsb_first   bit order (optional)      miso       serial data in
//     sclk/mosi   serial clock / data out   ss_n       slave selects (N_SS)
//     busy        transfer in progress      data_sent  end-of-transfer pulse
//     rx_data     captured MISO word (BITS)
// -----------------------------------------------------------------------------
interface spi_master_mode_if #(
    parameter int BITS = 8,
    parameter int N_SS = 1
);
    localparam int SS_W = (N_SS > 1) ? $clog2(N_SS) : 1;

    logic              data_ready;
    logic [BITS-1:0]   data;
    logic [SS_W-1:0]   cs_sel;
    logic              cpol;
    logic              cpha;
`ifdef SPI_LSB_FIRST_EN
    logic              lsb_first;
`endif
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic [N_SS-1:0]   ss_n;
    logic              busy;
    logic              data_sent;
    logic [BITS-1:0]   rx_data;

    modport slave (
`ifdef SPI_LSB_FIRST_EN
        input  lsb_first,
`endif
        input  data_ready,
        input  data,
        input  cs_sel,
        input  cpol,
        input  cpha,
        input  miso,
        output sclk,
        output mosi,
        output ss_n,
        output busy,
        output data_sent,
        output rx_data
    );

    modport master (
`ifdef SPI_LSB_FIRST_EN
        output lsb_first,
`endif
        output data_ready,
        output data,
        output cs_sel,
        output cpol,
        output cpha,
        output miso,
        input  sclk,
        input  mosi,
        input  ss_n,
        input  busy,
        input  data_sent,
        input  rx_data
    );
endinterface

// File: rtl/spi_master_mode.sv
// -----------------------------------------------------------------------------
// spi_master_mode
//   Full-duplex SPI master supporting all four CPOL/CPHA modes, a fixed SCLK
//   divider (CLK_DIV clk cycles per SCLK half-period), N_SS active-low slave
//   selects, a captured MISO word and a busy flag.
//
//   Optional feature macro: SPI_LSB_FIRST_EN. When defined, bus.lsb_first is
//   latched with each request and, when 1, both TX and RX run LSB first.
//   Without it every transfer is MSB first.
//
//   Ports
//     clk    system clock (rising edge)
//     rst_n  asynchronous active-low reset
//     bus    spi_master_mode_if.slave: command inputs, SPI pins, status
//
//   Sequence: IDLE -> SETUP (CLK_DIV) -> XFER (2*BITS half-periods)
//             -> HOLD (CLK_DIV) -> DONE (1 cycle, data_sent) -> IDLE.
//   All outputs are registered.
// -----------------------------------------------------------------------------
module spi_master_mode #(
    parameter int BITS    = 8,
    parameter int N_SS    = 1,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_master_mode_if.slave   bus
);
    localparam int SS_W   = (N_SS > 1) ? $clog2(N_SS) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALVES = 2 * BITS;
    localparam int K_W    = $clog2(HALVES + 1);
    localparam int IDX_W  = $clog2(BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t            state_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [K_W-1:0]    half_reg;     // index of the current XFER half-period
    logic [BITS-1:0]   tx_reg;
    logic [BITS-1:0]   rx_sh_reg;
    logic              cpol_reg;
    logic              cpha_reg;
    logic              lsb_reg;
    logic              sclk_reg;
    logic              mosi_reg;
    logic [N_SS-1:0]   ss_n_reg;
    logic              busy_reg;
    logic              sent_reg;
    logic [BITS-1:0]   rx_data_reg;

    // ------------------------------------------------------------------
    // Request qualification and slave-select decode
    // ------------------------------------------------------------------
    logic              lsb_in;
    logic              sel_ok;
    logic [N_SS-1:0]   sel_dec;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = bus.lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // When N_SS fills the index range every cs_sel value is legal.
    generate
        if ((1 << SS_W) == N_SS) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_part
            assign sel_ok = ({1'b0, bus.cs_sel} < (SS_W + 1)'(N_SS));
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_SS; gi++) begin : g_dec
            assign sel_dec[gi] = (bus.cs_sel == SS_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // SCLK toggle bookkeeping
    //   Toggle k (1..2*BITS) happens at the start of XFER half-period k.
    //   Odd k are leading edges, even k trailing. The bit driven at toggle
    //   k is bit number k/2 in transmission order for both CPHA settings.
    // ------------------------------------------------------------------
    logic              div_end;
    logic              last_half;
    logic              tog_fire;
    logic [K_W-1:0]    tog_k;
    logic              tog_lead;
    logic              do_drive;
    logic              do_sample;
    logic [IDX_W-1:0]  drv_idx;
    logic [IDX_W-1:0]  drv_pos;

    always_comb begin
        div_end   = (div_reg == DIV_W'(CLK_DIV - 1));
        last_half = (half_reg == K_W'(HALVES - 1));
        tog_fire  = 1'b0;
        tog_k     = '0;
        if (state_reg == ST_SETUP && div_end) begin
            tog_fire = 1'b1;
            tog_k    = K_W'(1);
        end else if (state_reg == ST_XFER && div_end && !last_half) begin
            tog_fire = 1'b1;
            tog_k    = half_reg + K_W'(2);
        end
        tog_lead  = tog_k[0];
        // CPHA=0 drives on trailing edges (never after the last one),
        // CPHA=1 drives on leading edges; sampling uses the other edge type.
        do_drive  = tog_fire && (tog_lead == cpha_reg) && (tog_k != K_W'(HALVES));
        do_sample = tog_fire && (tog_lead != cpha_reg);
        drv_idx   = tog_k[IDX_W:1];
        drv_pos   = lsb_reg ? drv_idx : (IDX_W'(BITS - 1) - drv_idx);
    end

    // ------------------------------------------------------------------
    // Main FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            div_reg     <= '0;
            half_reg    <= '0;
            tx_reg      <= '0;
            rx_sh_reg   <= '0;
            cpol_reg    <= 1'b0;
            cpha_reg    <= 1'b0;
            lsb_reg     <= 1'b0;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
            ss_n_reg    <= '1;
            busy_reg    <= 1'b0;
            sent_reg    <= 1'b0;
            rx_data_reg <= '0;
        end else begin
            sent_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    sclk_reg <= cpol_reg;
                    mosi_reg <= 1'b0;
                    if (bus.data_ready && sel_ok) begin
                        state_reg <= ST_SETUP;
                        div_reg   <= '0;
                        half_reg  <= '0;
                        tx_reg    <= bus.data;
                        rx_sh_reg <= '0;
                        cpol_reg  <= bus.cpol;
                        cpha_reg  <= bus.cpha;
                        lsb_reg   <= lsb_in;
                        sclk_reg  <= bus.cpol;
                        ss_n_reg  <= ~sel_dec;
                        busy_reg  <= 1'b1;
                        // CPHA=0 needs the first bit valid before the first edge.
                        mosi_reg  <= bus.cpha ? 1'b0
                                              : bus.data[lsb_in ? 0 : BITS - 1];
                    end
                end

                ST_SETUP: begin
                    if (div_end) begin
                        state_reg <= ST_XFER;
                        div_reg   <= '0;
                        half_reg  <= '0;
                        sclk_reg  <= ~sclk_reg;
                    end else begin
                        div_reg <= div_reg + DIV_W'(1);
                    end
                end

                ST_XFER: begin
                    if (div_end) begin
                        div_reg <= '0;
                        if (last_half) begin
                            state_reg <= ST_HOLD;
                        end else begin
                            half_reg <= half_reg + K_W'(1);
                            sclk_reg <= ~sclk_reg;
                        end
                    end else begin
                        div_reg <= div_reg + DIV_W'(1);
                    end
                end

                ST_HOLD: begin
                    sclk_reg <= cpol_reg;
                    if (div_end) begin
                        state_reg   <= ST_DONE;
                        div_reg     <= '0;
                        ss_n_reg    <= '1;
                        mosi_reg    <= 1'b0;
                        rx_data_reg <= rx_sh_reg;
                        sent_reg    <= 1'b1;
                    end else begin
                        div_reg <= div_reg + DIV_W'(1);
                    end
                end

                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    div_reg   <= '0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (do_drive) begin
                mosi_reg <= tx_reg[drv_pos];
            end

            // The shift direction matches the TX order so rx_sh_reg ends in
            // natural bit order after BITS samples.
            if (do_sample) begin
                if (lsb_reg) begin
                    rx_sh_reg <= {bus.miso, rx_sh_reg[BITS-1:1]};
                end else begin
                    rx_sh_reg <= {rx_sh_reg[BITS-2:0], bus.miso};
                end
            end
        end
    end

    assign bus.sclk      = sclk_reg;
    assign bus.mosi      = mosi_reg;
    assign bus.ss_n      = ss_n_reg;
    assign bus.busy      = busy_reg;
    assign bus.data_sent = sent_reg;
    assign bus.rx_data   = rx_data_reg;

endmodule

// File: tb/tb_spi_master_mode.sv
// -----------------------------------------------------------------------------
// tb_spi_master_mode
//   Directed bench for spi_master_mode. Main instance: BITS=8, N_SS=4,
//   CLK_DIV=2. A second instance with N_SS=3 covers the out-of-range
//   slave index. Outputs are sampled on the falling clock edge.
//   Build with SPI_LSB_FIRST_EN defined to include the LSB-first step.
// -----------------------------------------------------------------------------
module tb_spi_master_mode;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic loopback = 1'b0;
    logic miso_tie = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    spi_master_mode_if #(.BITS(8), .N_SS(4)) bus ();
    spi_master_mode_if #(.BITS(8), .N_SS(3)) bus3 ();

    assign bus.miso  = loopback ? bus.mosi : miso_tie;
    assign bus3.miso = 1'b0;

    spi_master_mode #(.BITS(8), .N_SS(4), .CLK_DIV(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    spi_master_mode #(.BITS(8), .N_SS(3), .CLK_DIV(2)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer on the main instance. repulse_c re-asserts
    // data_ready with data=0 at that cycle; abort_c asserts reset there.
    // c counts cycles after the accepting edge T (c=1 is the first sample).
    task automatic xfer(input string tag, input logic [7:0] d, input logic [1:0] cs,
                        input logic pol, input logic pha, input logic lsb,
                        input int repulse_c, input int abort_c,
                        input logic [3:0] ss_exp, input logic [7:0] rx_exp,
                        input logic [7:0] seq_exp);
        int c, lat, sent_cnt, leads;
        logic [7:0] seq;
        logic prev_sclk, done, aborted;
        @(negedge clk);
        bus.data       = d;
        bus.cs_sel     = cs;
        bus.cpol       = pol;
        bus.cpha       = pha;
`ifdef SPI_LSB_FIRST_EN
        bus.lsb_first  = lsb;
`endif
        bus.data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.data_ready = 1'b0;
        c = 1;
        chk({tag, "_busy_on"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_ss_on"}, {28'd0, bus.ss_n}, {28'd0, ss_exp});
        chk({tag, "_sclk_idle"}, {31'd0, bus.sclk}, {31'd0, pol});
        // Inputs changing while busy must not affect the transfer.
        bus.data   = ~d;
        bus.cs_sel = cs + 2'd1;
        lat = 0; sent_cnt = 0; leads = 0; seq = 8'h00;
        prev_sclk = bus.sclk; done = 1'b0; aborted = 1'b0;
        while (!done && c < 150) begin
            if (c == repulse_c) begin
                bus.data_ready = 1'b1;
                bus.data       = 8'h00;
            end
            if (c == repulse_c + 2) bus.data_ready = 1'b0;
            if (c == abort_c) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_abort_ss"}, {28'd0, bus.ss_n}, 32'hF);
                chk({tag, "_abort_sclk"}, {31'd0, bus.sclk}, 32'd0);
                chk({tag, "_abort_busy"}, {31'd0, bus.busy}, 32'd0);
                chk({tag, "_abort_rx"}, {24'd0, bus.rx_data}, 32'd0);
                aborted = 1'b1;
                done = 1'b1;
            end else begin
                if (bus.sclk != prev_sclk) begin
                    if (bus.sclk != pol) leads++;
                    // Slave's sampling edge: leading for CPHA=0, trailing for CPHA=1.
                    if ((bus.sclk != pol) != pha) seq = {seq[6:0], bus.mosi};
                    prev_sclk = bus.sclk;
                end
                if (c == 20) chk({tag, "_ss_mid"}, {28'd0, bus.ss_n}, {28'd0, ss_exp});
                if (bus.data_sent) begin
                    sent_cnt++;
                    if (lat == 0) begin
                        lat = c;
                        chk({tag, "_end_busy"}, {31'd0, bus.busy}, 32'd1);
                        chk({tag, "_end_ss"}, {28'd0, bus.ss_n}, 32'hF);
                        chk({tag, "_rx"}, {24'd0, bus.rx_data}, {24'd0, rx_exp});
                    end
                end
                if (lat != 0 && c == lat + 1)
                    chk({tag, "_busy_off"}, {31'd0, bus.busy}, 32'd0);
                if (lat != 0 && c == lat + 3) done = 1'b1;
                if (!done) begin
                    @(negedge clk);
                    c++;
                end
            end
        end
        if (!aborted) begin
            chk({tag, "_latency"}, lat, 32'd37);
            chk({tag, "_sent_cnt"}, sent_cnt, 32'd1);
            chk({tag, "_leads"}, leads, 32'd8);
            chk({tag, "_mosi_seq"}, {24'd0, seq}, {24'd0, seq_exp});
        end
        $display("xfer %s: data=%h cs=%0d mode=%0d lsb=%0d lat=%0d rx=%h seq=%h sent=%0d aborted=%0d",
                 tag, d, cs, {pol, pha}, lsb, lat, bus.rx_data, seq, sent_cnt, aborted);
    endtask

    initial begin
        int cnt;
        bus.data_ready = 1'b0; bus.data = 8'h00; bus.cs_sel = 2'd0;
        bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus3.data_ready = 1'b0; bus3.data = 8'h00; bus3.cs_sel = 2'd0;
        bus3.cpol = 1'b0; bus3.cpha = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
        bus3.lsb_first = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sclk", {31'd0, bus.sclk}, 32'd0);
        chk("rst_mosi", {31'd0, bus.mosi}, 32'd0);
        chk("rst_ss", {28'd0, bus.ss_n}, 32'hF);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_sent", {31'd0, bus.data_sent}, 32'd0);
        chk("rst_rx", {24'd0, bus.rx_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_sclk", {31'd0, bus.sclk}, 32'd0);

        // Mode 0, loopback
        loopback = 1'b1;
        xfer("t1_mode0", 8'h35, 2'd0, 1'b0, 1'b0, 1'b0, -1, -1, 4'b1110, 8'h35, 8'h35);

        // Mode 3, miso tied high
        loopback = 1'b0; miso_tie = 1'b1;
        xfer("t2_mode3", 8'hA5, 2'd0, 1'b1, 1'b1, 1'b0, -1, -1, 4'b1110, 8'hFF, 8'hA5);
        @(negedge clk);
        chk("t2_idle_sclk", {31'd0, bus.sclk}, 32'd1);

        // Slave 2 of 4, mode 1, loopback
        loopback = 1'b1;
        xfer("t3_cs2", 8'h5A, 2'd2, 1'b0, 1'b1, 1'b0, -1, -1, 4'b1011, 8'h5A, 8'h5A);

        // Out-of-range index on the N_SS=3 instance, then a legal one
        @(negedge clk);
        bus3.cs_sel = 2'd3; bus3.data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.data_ready = 1'b0;
        chk("t3_bad_busy", {31'd0, bus3.busy}, 32'd0);
        chk("t3_bad_ss", {29'd0, bus3.ss_n}, 32'h7);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus3.data_sent) cnt++;
        end
        chk("t3_bad_sent", cnt, 32'd0);
        $display("xfer t3_bad_cs: cs=3 on N_SS=3 busy=%0d ss_n=%b sent=%0d", bus3.busy, bus3.ss_n, cnt);
        bus3.cs_sel = 2'd2; bus3.data = 8'h0F; bus3.data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.data_ready = 1'b0;
        chk("t3_ok3_busy", {31'd0, bus3.busy}, 32'd1);
        chk("t3_ok3_ss", {29'd0, bus3.ss_n}, 32'h3);
        repeat (40) @(negedge clk);
        $display("xfer t3_ok3: cs=2 on N_SS=3 ss_n=%b busy=%0d", bus3.ss_n, bus3.busy);

        // Mode 2, re-pulse during transfer
        xfer("t4_repulse", 8'hC3, 2'd1, 1'b1, 1'b0, 1'b0, 10, -1, 4'b1101, 8'hC3, 8'hC3);

        // Reset at XFER half-period 5, then a fresh transfer
        xfer("t5_abort", 8'h96, 2'd0, 1'b0, 1'b0, 1'b0, -1, 11, 4'b1110, 8'h00, 8'h00);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.data_sent) cnt++;
        end
        chk("t5_no_sent", cnt, 32'd0);
        rst_n = 1'b1;
        xfer("t5_after", 8'h81, 2'd3, 1'b0, 1'b0, 1'b0, -1, -1, 4'b0111, 8'h81, 8'h81);

`ifdef SPI_LSB_FIRST_EN
        xfer("t6_lsb", 8'h01, 2'd0, 1'b0, 1'b0, 1'b1, -1, -1, 4'b1110, 8'h01, 8'h80);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
